// File: rtl/dual_wb_arbiter_if.sv
// Lane-result and register-file write bundle for dual_wb_arbiter (fwd_* present only with WB_FORWARD_EN).
// The slave modport is the arbiter side; the master modport is the producer / regfile side.
interface dual_wb_arbiter_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic                      lane0_valid;
   logic [ADDR_W-1:0]         lane0_rd;
   logic [DATA_W-1:0]         lane0_data;
   logic                      lane1_valid;
   logic [ADDR_W-1:0]         lane1_rd;
   logic [DATA_W-1:0]         lane1_data;
   logic                      in_ready;
   logic [ADDR_W-1:0]         write_reg;
   logic [DATA_W-1:0]         write_data;
   logic                      reg_write;
   logic [$clog2(DEPTH):0]    pending_count;
   logic                      busy;
`ifdef WB_FORWARD_EN
   logic [ADDR_W-1:0]         fwd_rs;
   logic                      fwd_hit;
   logic [DATA_W-1:0]         fwd_data;

   modport slave (
      input  lane0_valid, lane0_rd, lane0_data, lane1_valid, lane1_rd, lane1_data, fwd_rs,
      output in_ready, write_reg, write_data, reg_write, pending_count, busy, fwd_hit, fwd_data
   );
   modport master (
      output lane0_valid, lane0_rd, lane0_data, lane1_valid, lane1_rd, lane1_data, fwd_rs,
      input  in_ready, write_reg, write_data, reg_write, pending_count, busy, fwd_hit, fwd_data
   );
`else
   modport slave (
      input  lane0_valid, lane0_rd, lane0_data, lane1_valid, lane1_rd, lane1_data,
      output in_ready, write_reg, write_data, reg_write, pending_count, busy
   );
   modport master (
      output lane0_valid, lane0_rd, lane0_data, lane1_valid, lane1_rd, lane1_data,
      input  in_ready, write_reg, write_data, reg_write, pending_count, busy
   );
`endif
endinterface

// File: rtl/dual_wb_arbiter.sv
// Two-lane writeback queue onto a single regfile write port; accept at edge N, write visible after N+1.
// in_ready drops when fewer than two slots are free; optional forwarding lookup under WB_FORWARD_EN.
module dual_wb_arbiter #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input logic               clk,
   input logic               rst_n,
   dual_wb_arbiter_if.slave  wb
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_fifo_rd   [DEPTH];
   logic [DATA_W-1:0] r_fifo_data [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_reg_write;
   logic [ADDR_W-1:0] r_write_reg;
   logic [DATA_W-1:0] r_write_data;

   logic              w_in_ready;
   logic              w_keep0;
   logic              w_keep1;
   logic              w_deq;
   logic [1:0]        w_enq_n;
   logic [PTR_W-1:0]  w_wptr1;

   assign w_in_ready = (r_count <= CNT_W'(DEPTH - 2));

   // Lane 0 is dead when the younger lane 1 overwrites the same register this cycle.
   assign w_keep0 = w_in_ready && wb.lane0_valid && (wb.lane0_rd != '0) &&
                    !(wb.lane1_valid && (wb.lane1_rd == wb.lane0_rd));
   assign w_keep1 = w_in_ready && wb.lane1_valid && (wb.lane1_rd != '0);
   assign w_enq_n = {1'b0, w_keep0} + {1'b0, w_keep1};
   assign w_wptr1 = r_wptr + PTR_W'(w_keep0);
   assign w_deq   = (r_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_fifo_rd[i]   <= '0;
            r_fifo_data[i] <= '0;
         end
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_reg_write  <= 1'b0;
         r_write_reg  <= '0;
         r_write_data <= '0;
      end else begin
         if (w_keep0) begin
            r_fifo_rd[r_wptr]   <= wb.lane0_rd;
            r_fifo_data[r_wptr] <= wb.lane0_data;
         end
         if (w_keep1) begin
            r_fifo_rd[w_wptr1]   <= wb.lane1_rd;
            r_fifo_data[w_wptr1] <= wb.lane1_data;
         end
         r_wptr      <= r_wptr + PTR_W'(w_enq_n);
         r_reg_write <= w_deq;
         if (w_deq) begin
            r_write_reg  <= r_fifo_rd[r_rptr];
            r_write_data <= r_fifo_data[r_rptr];
            r_rptr       <= r_rptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_enq_n) - CNT_W'(w_deq);
      end
   end

   assign wb.in_ready      = w_in_ready;
   assign wb.write_reg     = r_write_reg;
   assign wb.write_data    = r_write_data;
   assign wb.reg_write     = r_reg_write;
   assign wb.pending_count = r_count;
   assign wb.busy          = w_deq | r_reg_write;

`ifdef WB_FORWARD_EN
   logic              w_fwd_hit;
   logic [DATA_W-1:0] w_fwd_data;

   // Walk head to tail so the youngest queued match overrides the output register.
   always_comb begin
      logic [PTR_W-1:0] w_idx;
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
      w_idx      = r_rptr;
      if (wb.fwd_rs != '0) begin
         if (r_reg_write && (r_write_reg == wb.fwd_rs)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_write_data;
         end
         for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rptr + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_fifo_rd[w_idx] == wb.fwd_rs)) begin
               w_fwd_hit  = 1'b1;
               w_fwd_data = r_fifo_data[w_idx];
            end
         end
      end
   end

   assign wb.fwd_hit  = w_fwd_hit;
   assign wb.fwd_data = w_fwd_data;
`endif
endmodule
